// File: rtl/alu_seq64.sv
// alu_seq64: multi-cycle 64-bit ALU fed by the register-bank read ports.
// Logic/add/shift/compare ops finish in one cycle. MUL/MULH/DIV/REM share one
// iterative shift-add / restoring shift-subtract datapath that runs WIDTH steps.
module alu_seq64 #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opr,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] outAB,
  output logic             done,
  output logic             busy,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_MULH = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_REM  = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_opr;
  logic [WIDTH-1:0] r_a, r_b;
  // Shared accumulator: MUL = {product high, product low};
  // DIV = {partial remainder, quotient shift register}.
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_out;
  logic             r_done, r_busy, r_zero, r_carry, r_ovf, r_err;

  logic             w_in_mul, w_in_div, w_go_iter, w_mul_sel;
  logic [WIDTH:0]   w_mul_sum, w_div_sh, w_div_sub;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_e;

  assign w_in_mul  = (opr == OP_MUL) || (opr == OP_MULH);
  assign w_in_div  = (opr == OP_DIV) || (opr == OP_REM);
  // Divide-by-zero skips the iterations and is resolved in FIN.
  assign w_go_iter = w_in_mul || (w_in_div && (inB != '0));
  assign w_mul_sel = (r_opr == OP_MUL) || (r_opr == OP_MULH);

  // One shift-add step: conditionally add multiplicand, then shift right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  // Partial remainder < divisor keeps the difference within WIDTH+1 bits,
  // so the top bit is a reliable borrow.
  assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_sub = w_div_sh - {1'b0, r_b};

  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_go_iter ? S_ITER : S_FIN;
      S_ITER: if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result and flag selection from the latched operation, used in FIN.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_e   = 1'b0;
    case (r_opr)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_SHL:  w_res = r_a << r_b[CW-1:0];
      OP_SHR:  w_res = r_a >> r_b[CW-1:0];
      OP_SRA:  w_res = $signed(r_a) >>> r_b[CW-1:0];
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_MUL:  w_res = r_lo;
      OP_MULH: w_res = r_hi;
      OP_DIV: begin
        w_res = (r_b == '0) ? '1 : r_lo;
        w_e   = (r_b == '0);
      end
      OP_REM: begin
        w_res = (r_b == '0) ? r_a : r_hi;
        w_e   = (r_b == '0);
      end
      default: w_e = 1'b1;
    endcase
  end

  // Control state, counter, result register and flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_busy <= start;
        end
        S_ITER: begin
          r_cnt  <= r_cnt + 1'b1;
          r_busy <= 1'b1;
        end
        default: begin
          r_busy  <= 1'b1;
          r_out   <= w_res;
          r_zero  <= (w_res == '0);
          r_carry <= w_c;
          r_ovf   <= w_v;
          r_err   <= w_e;
        end
      endcase
    end
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && start) begin
      r_opr <= opr;
      r_a   <= inA;
      r_b   <= inB;
      r_hi  <= '0;
      r_lo  <= w_in_mul ? inB : inA;
    end else if (r_state == S_ITER) begin
      if (w_mul_sel) begin
        r_hi <= w_mul_sum[WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end else if (!w_div_sub[WIDTH]) begin
        r_hi <= w_div_sub[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        r_hi <= w_div_sh[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign outAB = r_out;
  assign done  = r_done;
  assign busy  = r_busy;
  assign zero  = r_zero;
  assign carry = r_carry;
  assign ovf   = r_ovf;
  assign err   = r_err;

endmodule

// File: tb/tb_alu_seq64.sv
// Directed bench for alu_seq64: reset, single-cycle ops, iterative MUL/DIV,
// divide-by-zero, reserved codes, register-bank XOR chain, back-to-back
// throughput with start held high and reset abort mid-multiply.
module tb_alu_seq64;

  logic        clock, reset, start;
  logic [3:0]  opr;
  logic [63:0] inA, inB, outAB;
  logic        done, busy, zero, carry, ovf, err;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] regs [16];

  alu_seq64 #(.WIDTH(64)) dut (
    .clock(clock), .reset(reset), .start(start), .opr(opr),
    .inA(inA), .inB(inB), .outAB(outAB), .done(done), .busy(busy),
    .zero(zero), .carry(carry), .ovf(ovf), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE (called #1 after a posedge), wait for done with a
  // cycle bound, check latency/result/flags, then confirm busy drops.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input int lat, input logic [63:0] exp,
                       input logic ez, input logic ec, input logic ev, input logic ee,
                       input int pulse_at);
    int cycles;
    start = 1'b1; opr = op; inA = a; inB = b;
    @(posedge clock); #1;
    start = 1'b0; opr = 4'd2; inA = ~a; inB = ~b;
    check({tag, "_busy_acc"}, 64'(busy), 64'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 200) begin
      start = (cycles == pulse_at);
      @(posedge clock); #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, "_lat"},   64'(cycles), 64'(lat));
    check({tag, "_out"},   outAB, exp);
    check({tag, "_zero"},  64'(zero),  64'(ez));
    check({tag, "_carry"}, 64'(carry), 64'(ec));
    check({tag, "_ovf"},   64'(ovf),   64'(ev));
    check({tag, "_err"},   64'(err),   64'(ee));
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_idle"},  64'(busy), 64'd0);
  endtask

  initial begin
    int n_done;
    reset = 1'b0; start = 1'b0; opr = '0; inA = '0; inB = '0;
    #10 reset = 1'b1;
    @(posedge clock); #1;
    check("rst_out",   outAB, 64'd0);
    check("rst_zero",  64'(zero),  64'd1);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_flags", {61'd0, carry, ovf, err}, 64'd0);

    do_op("add_ovf", 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'h8000_0000_0000_0000, 0, 0, 1, 0, -1);
    do_op("add_cy",  4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'd0, 1, 1, 0, 0, -1);
    do_op("sub",     4'd1, 64'd5, 64'd7, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, -1);
    do_op("slt",     4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'd1, 0, 0, 0, 0, -1);
    do_op("sra",     4'd7, 64'h8000_0000_0000_0000, 64'd63, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, -1);
    do_op("shl64",   4'd5, 64'd1, 64'h40, 1, 64'd1, 0, 0, 0, 0, -1);
    do_op("shr",     4'd6, 64'hF000_0000_0000_0000, 64'd4, 1, 64'h0F00_0000_0000_0000, 0, 0, 0, 0, -1);
    do_op("and",     4'd2, 64'hFF00_FF00_1234_5678, 64'h0FF0_0FF0_FFFF_0000, 1, 64'h0F00_0F00_1234_0000, 0, 0, 0, 0, -1);
    do_op("or",      4'd3, 64'hF0, 64'h0F, 1, 64'hFF, 0, 0, 0, 0, -1);
    do_op("mul",     4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'd1, 0, 0, 0, 0, 30);
    do_op("mulh",    4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, -1);
    do_op("mul_sm",  4'd9,  64'd123456789, 64'd1000, 65, 64'd123456789000, 0, 0, 0, 0, -1);
    do_op("div",     4'd11, 64'd1000, 64'd7, 65, 64'd142, 0, 0, 0, 0, -1);
    do_op("rem",     4'd12, 64'd1000, 64'd7, 65, 64'd6, 0, 0, 0, 0, -1);
    do_op("div0",    4'd11, 64'd1000, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, -1);
    do_op("rem0",    4'd12, 64'd1000, 64'd0, 1, 64'd1000, 0, 0, 0, 1, -1);
    do_op("rsvd",    4'd14, 64'd55, 64'd66, 1, 64'd0, 1, 0, 0, 1, -1);

    for (int i = 0; i < 16; i++) regs[i] = 64'(i + 16) * 64'h0001_0003_0007_000F;
    for (int i = 0; i < 16; i++) begin
      do_op("xor_rb", 4'd4, regs[i], regs[i], 1, 64'd0, 1, 0, 0, 0, -1);
    end

    // Back-to-back ADDs with start held: done on every second edge.
    start = 1'b1; opr = 4'd0; inA = 64'd3; inB = 64'd4;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("b2b_done", 64'(done), 64'(i % 2));
      check("b2b_busy", 64'(busy), 64'd1);
      if (done) begin
        n_done++;
        check("b2b_out", outAB, 64'd7);
      end
    end
    check("b2b_count", 64'(n_done), 64'd5);
    start = 1'b0;
    @(posedge clock); #1;
    check("b2b_idle", 64'(busy), 64'd0);

    // Reset 20 cycles into a MUL aborts it with no done.
    start = 1'b1; opr = 4'd9; inA = 64'd9; inB = 64'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (20) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out",  outAB, 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    #10 reset = 1'b1;
    n_done = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_idle",    64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
